// File: rtl/key_event_if.sv
// Key event queue bundle: scanner vector in, key codes and status out.
// master is the queue side, slave is the scanner/consumer side.
interface key_event_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [15:0]    keys;
    logic           key_ready;
    logic           clear_ovf;
    logic [3:0]     key_code;
    logic           key_valid;
    logic [PTR_W:0] fifo_count;
    logic           any_pressed;
    logic           overflow;

    modport master (
        input  keys,
        input  key_ready,
        input  clear_ovf,
        output key_code,
        output key_valid,
        output fifo_count,
        output any_pressed,
        output overflow
    );

    modport slave (
        output keys,
        output key_ready,
        output clear_ovf,
        input  key_code,
        input  key_valid,
        input  fifo_count,
        input  any_pressed,
        input  overflow
    );
endinterface

// File: rtl/key_event_queue.sv
// Debounces the keypad vector, detects presses and queues their codes
// lowest index first in a show-ahead FIFO with sticky overflow.
module key_event_queue #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    key_event_if.master  kif
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

    logic [15:0]      sync_q;
    logic [15:0]      cand_q, cand_d;
    logic [15:0]      db_q, db_d;
    logic [15:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             commit;
    logic [15:0]      rise;
    logic [3:0]       head_idx;
    logic [15:0]      push_bit;
    logic             push;
    logic             pop;
    logic             lost;

    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Debounce: any change restarts the stability window; once the
    // window is full the counter saturates and commits every cycle.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        db_d   = db_q;
        commit = 1'b0;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            commit = 1'b1;
            db_d   = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rise     = commit ? (cand_q & ~db_q) : '0;
        pop      = (count_q != '0) && kif.key_ready;
        head_idx = lowest_idx(pend_q);
        push     = (pend_q != '0) && ((count_q != DEPTH_C) || pop);
        push_bit = push ? (16'd1 << head_idx) : '0;
        pend_d   = (pend_q & ~push_bit) | rise;
        lost     = |(rise & pend_q & ~push_bit);
        ovf_d    = lost | (ovf_q & ~kif.clear_ovf);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cand_q   <= '0;
            db_q     <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q   <= kif.keys;
            cand_q   <= cand_d;
            db_q     <= db_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= head_idx;
        end
    end

    assign kif.key_code    = mem_q[rd_ptr_q];
    assign kif.key_valid   = (count_q != '0);
    assign kif.fifo_count  = count_q;
    assign kif.any_pressed = |db_q;
    assign kif.overflow    = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue with STABLE_CYCLES=4, depth 4.
// Expected codes are queued at press time and checked on each pop.
module tb_key_event_queue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_event_if #(.FIFO_DEPTH(4)) kif ();

    key_event_queue #(
        .STABLE_CYCLES(4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb_q [$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        kif.keys = 16'(32'd1 << k);
        tick(6);
        kif.keys = 16'h0000;
        tick(6);
    endtask

    // A pop happens at the next posedge whenever valid&ready here.
    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) begin
            if (sb_q.size() == 0)
                chk("pop_unexpected", 32'(kif.key_code), 99);
            else
                chk("pop_code", 32'(kif.key_code), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        kif.keys      = 16'h0000;
        kif.key_ready = 1'b0;
        kif.clear_ovf = 1'b0;
        tick(3);
        chk("rst_code",  32'(kif.key_code), 0);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_count", 32'(kif.fifo_count), 0);
        chk("rst_any",   32'(kif.any_pressed), 0);
        chk("rst_ovf",   32'(kif.overflow), 0);

        // single press latency
        rst      = 1'b0;
        kif.keys = 16'h0020;
        sb_q.push_back(4'd5);
        tick(6);
        chk("t1_valid_e6", 32'(kif.key_valid), 0);
        tick(1);
        chk("t1_valid_e7", 32'(kif.key_valid), 1);
        chk("t1_code", 32'(kif.key_code), 5);
        chk("t1_any", 32'(kif.any_pressed), 1);
        kif.key_ready = 1'b1;
        tick(1);
        kif.key_ready = 1'b0;
        chk("t1_valid_pop", 32'(kif.key_valid), 0);
        chk("t1_count_pop", 32'(kif.fifo_count), 0);
        kif.keys = 16'h0000;
        tick(10);
        chk("t1_any_rel", 32'(kif.any_pressed), 0);

        // bounce shorter than the window
        for (int i = 0; i < 10; i++) begin
            kif.keys = (i % 2 == 1) ? 16'h0008 : 16'h0000;
            tick(2);
            chk("t2_valid", 32'(kif.key_valid), 0);
        end
        kif.keys = 16'h0000;
        tick(10);
        chk("t2_valid_end", 32'(kif.key_valid), 0);
        chk("t2_any_end", 32'(kif.any_pressed), 0);

        // simultaneous presses serialized ascending
        kif.keys = 16'h8101;
        sb_q.push_back(4'd0);
        sb_q.push_back(4'd8);
        sb_q.push_back(4'd15);
        tick(8);
        chk("t3_count_e8", 32'(kif.fifo_count), 2);
        tick(1);
        chk("t3_count_e9", 32'(kif.fifo_count), 3);
        kif.key_ready = 1'b1;
        tick(3);
        kif.key_ready = 1'b0;
        chk("t3_count_drained", 32'(kif.fifo_count), 0);
        kif.keys = 16'h0000;
        tick(10);

        // backpressure into pending, then overflow
        for (int k = 1; k <= 6; k++) begin
            press(k);
            sb_q.push_back(4'(k));
        end
        chk("t4_count_full", 32'(kif.fifo_count), 4);
        chk("t4_ovf_none", 32'(kif.overflow), 0);
        press(5);
        chk("t4_ovf_set", 32'(kif.overflow), 1);
        chk("t4_count_still", 32'(kif.fifo_count), 4);
        kif.key_ready = 1'b1;
        tick(8);
        kif.key_ready = 1'b0;
        chk("t4_count_drained", 32'(kif.fifo_count), 0);
        chk("t4_valid_drained", 32'(kif.key_valid), 0);
        chk("t4_ovf_sticky", 32'(kif.overflow), 1);
        kif.clear_ovf = 1'b1;
        tick(1);
        kif.clear_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(kif.overflow), 0);

        // full FIFO with pending: pop+push per cycle, pointers wrap
        for (int k = 6; k <= 15; k++) begin
            press(k);
            sb_q.push_back(4'(k));
        end
        chk("t5_count_full", 32'(kif.fifo_count), 4);
        kif.key_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t5_count_hold", 32'(kif.fifo_count), 4);
        end
        tick(4);
        kif.key_ready = 1'b0;
        chk("t5_count_drained", 32'(kif.fifo_count), 0);
        chk("t5_ovf", 32'(kif.overflow), 0);

        // reset mid-operation
        kif.keys = 16'h000F;
        tick(9);
        chk("t6_count_pre", 32'(kif.fifo_count), 3);
        rst      = 1'b1;
        kif.keys = 16'h0001;
        sb_q.delete();
        tick(1);
        chk("t6_code",  32'(kif.key_code), 0);
        chk("t6_valid", 32'(kif.key_valid), 0);
        chk("t6_count", 32'(kif.fifo_count), 0);
        chk("t6_any",   32'(kif.any_pressed), 0);
        chk("t6_ovf",   32'(kif.overflow), 0);
        tick(1);
        rst = 1'b0;
        sb_q.push_back(4'd0);
        tick(6);
        chk("t6_valid_e6", 32'(kif.key_valid), 0);
        tick(1);
        chk("t6_valid_e7", 32'(kif.key_valid), 1);
        chk("t6_count_e7", 32'(kif.fifo_count), 1);
        kif.key_ready = 1'b1;
        tick(1);
        kif.key_ready = 1'b0;
        chk("t6_count_pop", 32'(kif.fifo_count), 0);
        tick(2);
        chk("t6_no_extra", 32'(kif.key_valid), 0);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the keypad scanner and consumes its 16-bit key-state vector.
- Debounces the vector and detects new key presses.
- Serializes simultaneous presses in ascending key-index order and buffers the resulting 4-bit key codes in a small show-ahead FIFO.
- Game/control logic pops codes with a valid/ready handshake; overflow is flagged sticky.

Parameters:
STABLE_CYCLES, 1000000, cycles the vector must stay unchanged before it is accepted (≥2); 10 ms at 100 MHz
FIFO_DEPTH, 4, code FIFO entries; power of two, ≥2
CNT_W, $clog2(STABLE_CYCLES)+1, localparam, debounce counter width
PTR_W, $clog2(FIFO_DEPTH), localparam, FIFO pointer width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
keys  in  16  scanner key state; bit i = 1 means key i pressed
key_ready  in  1  consumer accepts key_code this cycle
clear_ovf  in  1  clears overflow (synchronous, one cycle)
key_code  out  4  key index at FIFO head
key_valid  out  1  FIFO non-empty
fifo_count  out  PTR_W+1  entries held, 0..FIFO_DEPTH
any_pressed  out  1  OR of debounced state
overflow  out  1  sticky: a press was lost

Behaviour:
Reset (rst=1 at posedge):
- sync_r, cand, db, pending, count, pointers, cnt all go to 0.
- Outputs after reset: key_code=0, key_valid=0, fifo_count=0, any_pressed=0, overflow=0.
- rst mid-operation discards FIFO contents and pending presses.
- A key held through reset is reported as a new press once debounced, since db restarts at 0.

Sampling:
- sync_r <= keys every cycle.

Debounce:
- If sync_r != cand: cand <= sync_r, cnt <= 0.
- Else if cnt == STABLE_CYCLES-1: commit db <= cand; cnt holds (saturates).
- Else: cnt <= cnt+1.
- A commit with cand == db is a no-op.

Press detect:
- On commit, rise = cand & ~db, and pending <= (pending & ~pushed_bit) | rise.
- Releases never clear pending; a registered press is always delivered.
- If a rise bit is already set in pending and not being pushed this cycle, set overflow.

Push:
- Each cycle, if pending != 0 and (count < FIFO_DEPTH or pop this cycle):
  - write the lowest set index of pending to mem[wr_ptr];
  - wr_ptr++ (wraps modulo FIFO_DEPTH);
  - clear that pending bit.
- At most one push per cycle.
- FIFO full with no pop: pending holds (backpressure); no loss.

Pop:
- pop = key_valid & key_ready; rd_ptr++ (wraps modulo FIFO_DEPTH).
- key_code = mem[rd_ptr] combinationally (show-ahead).
- key_ready while empty is ignored.

Count:
- count += push − pop.
- Simultaneous push and pop when full: count stays FIFO_DEPTH.
- Simultaneous push and pop when count==1: count stays 1, key_code switches to the new entry.

Overflow and status:
- overflow: set as above; cleared by clear_ovf; set wins over clear in the same cycle.
- any_pressed = |db.

Latency:
- Keys is first sampled with its new value at edge E1 and held stable.
- With the FIFO empty, db updates at edge E(STABLE_CYCLES+2).
- key_valid is high after edge E(STABLE_CYCLES+3).
- Changes of keys shorter than STABLE_CYCLES cycles are never committed.

Test Plan (STABLE_CYCLES=4, FIFO_DEPTH=4):
1. Reset with keys=16'h0000, then keys=16'h0020 held → key_valid rises after the 7th edge, key_code=5, any_pressed=1; key_ready=1 for one cycle → key_valid=0, fifo_count=0.
2. keys toggles 0x0000/0x0008 every 2 cycles for 20 cycles, then 0x0000 → no key_valid, db stays 0.
3. keys=16'h8101 held → codes 0, 8, 15 pushed on consecutive cycles, fifo_count reaches 3; pops return 0, 8, 15 in that order.
4. key_ready=0; press and release keys 1..6 one at a time (each held 6 cycles, gaps of 6) → FIFO holds 1, 2, 3, 4 and pending holds 5, 6; overflow=0. A second press of key 5 → overflow=1. Popping then drains 1, 2, 3, 4, 5, 6. clear_ovf → overflow=0.
5. FIFO full, pending=1, key_ready=1 held → one pop and one push in the same cycle, fifo_count stays 4; wr_ptr and rd_ptr wrap correctly over 10 operations.
6. rst asserted with fifo_count=3 and pending≠0 → next cycle all outputs are 0. keys still 0x0001 → code 0 is re-reported 7 edges after reset release.
